cache_miss_ctrl: RTL and testbench

CACHE_MISS_CTRL -- requirements
Module: cache_miss_ctrl

---
 rtl/cache_miss_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_cache_miss_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_miss_ctrl.sv
// Blocking read-miss controller for a 4-way set-associative cache with per-set tree PLRU.
// Define CACHE_MISS_CTRL_STATS_EN to add saturating hit_count/miss_count outputs.
module cache_miss_ctrl #(
  parameter int TAG_W = 22,
  parameter int IDX_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic [31:0]       cpu_addr,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  output logic              arr_rd_en,
  output logic [IDX_W-1:0]  arr_index,
  input  logic [TAG_W-1:0]  way_tag0,
  input  logic [TAG_W-1:0]  way_tag1,
  input  logic [TAG_W-1:0]  way_tag2,
  input  logic [TAG_W-1:0]  way_tag3,
  input  logic              way_valid0,
  input  logic              way_valid1,
  input  logic              way_valid2,
  input  logic              way_valid3,
  input  logic [31:0]       way_data0,
  input  logic [31:0]       way_data1,
  input  logic [31:0]       way_data2,
  input  logic [31:0]       way_data3,
  output logic              arr_wr_en,
  output logic [1:0]        arr_wr_way,
  output logic [TAG_W-1:0]  arr_wr_tag,
  output logic [31:0]       arr_wr_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [31:0]       mem_addr,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
`ifdef CACHE_MISS_CTRL_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);

  typedef enum logic [2:0] {IDLE, READ, LOOKUP, MISS_REQ, MISS_WAIT, FILL, RESP} state_t;

  state_t            state, next_state;
  logic [31:0]       addr_q;
  logic [31:0]       fill_data;
  logic [1:0]        victim;
  logic [2:0]        plru [2**IDX_W];

  logic [IDX_W-1:0]  index;
  logic [TAG_W-1:0]  tag;
  logic [2:0]        plru_cur;
  logic [3:0]        hit;
  logic              any_hit;
  logic [1:0]        hit_way;
  logic [31:0]       hit_data;
  logic [1:0]        victim_sel;

  assign index    = addr_q[IDX_W+1:2];
  assign tag      = addr_q[31 -: TAG_W];
  assign plru_cur = plru[index];

  // Bit 0 picks the older pair (0 = ways 0/1), bit 1 the older of 0/1, bit 2 the older of 2/3.
  function automatic logic [2:0] plru_touch(input logic [2:0] bits, input logic [1:0] way);
    logic [2:0] r;
    r = bits;
    case (way)
      2'd0: begin r[0] = 1'b1; r[1] = 1'b1; end
      2'd1: begin r[0] = 1'b1; r[1] = 1'b0; end
      2'd2: begin r[0] = 1'b0; r[2] = 1'b1; end
      default: begin r[0] = 1'b0; r[2] = 1'b0; end
    endcase
    return r;
  endfunction

  always_comb begin
    hit[0]     = way_valid0 && (way_tag0 == tag);
    hit[1]     = way_valid1 && (way_tag1 == tag);
    hit[2]     = way_valid2 && (way_tag2 == tag);
    hit[3]     = way_valid3 && (way_tag3 == tag);
    any_hit    = |hit;
    hit_way    = 2'd0;
    hit_data   = way_data0;
    if (hit[0])      begin hit_way = 2'd0; hit_data = way_data0; end
    else if (hit[1]) begin hit_way = 2'd1; hit_data = way_data1; end
    else if (hit[2]) begin hit_way = 2'd2; hit_data = way_data2; end
    else if (hit[3]) begin hit_way = 2'd3; hit_data = way_data3; end
    if (!way_valid0)      victim_sel = 2'd0;
    else if (!way_valid1) victim_sel = 2'd1;
    else if (!way_valid2) victim_sel = 2'd2;
    else if (!way_valid3) victim_sel = 2'd3;
    else if (!plru_cur[0]) victim_sel = {1'b0, plru_cur[1]};
    else                  victim_sel = {1'b1, plru_cur[2]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      fill_data <= '0;
      victim    <= '0;
      cpu_rdata <= '0;
      for (int i = 0; i < 2**IDX_W; i++) plru[i] <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: if (cpu_req_valid) addr_q <= cpu_addr;
        LOOKUP: begin
          if (any_hit) begin
            cpu_rdata   <= hit_data;
            plru[index] <= plru_touch(plru_cur, hit_way);
          end else begin
            victim <= victim_sel;
          end
        end
        MISS_WAIT: if (mem_rvalid) fill_data <= mem_rdata;
        FILL: begin
          cpu_rdata   <= fill_data;
          plru[index] <= plru_touch(plru_cur, victim);
        end
        default: ;
      endcase
    end
  end

`ifdef CACHE_MISS_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == LOOKUP) begin
      if (any_hit && hit_count != 16'hFFFF)    hit_count  <= hit_count + 16'd1;
      if (!any_hit && miss_count != 16'hFFFF)  miss_count <= miss_count + 16'd1;
    end
  end
`endif

  always_comb begin
    next_state    = state;
    cpu_req_ready = 1'b0;
    cpu_rvalid    = 1'b0;
    arr_rd_en     = 1'b0;
    arr_index     = '0;
    arr_wr_en     = 1'b0;
    arr_wr_way    = '0;
    arr_wr_tag    = '0;
    arr_wr_data   = '0;
    mem_req_valid = 1'b0;
    mem_addr      = '0;
    case (state)
      IDLE: begin
        cpu_req_ready = 1'b1;
        if (cpu_req_valid) next_state = READ;
      end
      READ: begin
        arr_rd_en  = 1'b1;
        arr_index  = index;
        next_state = LOOKUP;
      end
      LOOKUP: next_state = any_hit ? RESP : MISS_REQ;
      MISS_REQ: begin
        mem_req_valid = 1'b1;
        mem_addr      = addr_q & 32'hFFFF_FFFC;
        if (mem_req_ready) next_state = MISS_WAIT;
      end
      MISS_WAIT: if (mem_rvalid) next_state = FILL;
      FILL: begin
        arr_wr_en   = 1'b1;
        arr_wr_way  = victim;
        arr_wr_tag  = tag;
        arr_wr_data = fill_data;
        next_state  = RESP;
      end
      RESP: begin
        cpu_rvalid = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed self-checking bench for cache_miss_ctrl; stats checks compile in with CACHE_MISS_CTRL_STATS_EN.
module tb_cache_miss_ctrl;
  localparam int TAG_W = 22;
  localparam int IDX_W = 8;

  logic clk, rst, cpu_req_valid, cpu_req_ready, cpu_rvalid;
  logic [31:0] cpu_addr, cpu_rdata;
  logic arr_rd_en, arr_wr_en;
  logic [IDX_W-1:0] arr_index;
  logic [TAG_W-1:0] way_tag0, way_tag1, way_tag2, way_tag3, arr_wr_tag;
  logic way_valid0, way_valid1, way_valid2, way_valid3;
  logic [31:0] way_data0, way_data1, way_data2, way_data3, arr_wr_data;
  logic [1:0] arr_wr_way;
  logic mem_req_valid, mem_req_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_rdata;
`ifdef CACHE_MISS_CTRL_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  int checks = 0;
  int fails = 0;

  cache_miss_ctrl #(.TAG_W(TAG_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_addr(cpu_addr),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .arr_rd_en(arr_rd_en), .arr_index(arr_index),
    .way_tag0(way_tag0), .way_tag1(way_tag1), .way_tag2(way_tag2), .way_tag3(way_tag3),
    .way_valid0(way_valid0), .way_valid1(way_valid1), .way_valid2(way_valid2), .way_valid3(way_valid3),
    .way_data0(way_data0), .way_data1(way_data1), .way_data2(way_data2), .way_data3(way_data3),
    .arr_wr_en(arr_wr_en), .arr_wr_way(arr_wr_way), .arr_wr_tag(arr_wr_tag), .arr_wr_data(arr_wr_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef CACHE_MISS_CTRL_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ways(input logic [TAG_W-1:0] t0, t1, t2, t3, input logic [3:0] v,
                          input logic [31:0] d0, d1, d2, d3);
    way_tag0 = t0; way_tag1 = t1; way_tag2 = t2; way_tag3 = t3;
    way_valid0 = v[0]; way_valid1 = v[1]; way_valid2 = v[2]; way_valid3 = v[3];
    way_data0 = d0; way_data1 = d1; way_data2 = d2; way_data3 = d3;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic do_hit(input logic [31:0] a, output logic [31:0] rdata, output logic rv);
    cpu_req_valid = 1'b1; cpu_addr = a;
    cycle();
    cpu_req_valid = 1'b0;
    cycle();
    cycle();
    rv = cpu_rvalid; rdata = cpu_rdata;
    cycle();
  endtask

  task automatic do_miss(input logic [31:0] a, input logic [31:0] md, output logic [1:0] way, output logic we);
    cpu_req_valid = 1'b1; cpu_addr = a;
    cycle();
    cpu_req_valid = 1'b0;
    cycle();
    cycle();
    mem_req_ready = 1'b1;
    cycle();
    mem_req_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = md;
    cycle();
    mem_rvalid = 1'b0;
    we = arr_wr_en; way = arr_wr_way;
    cycle();
    cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_req_valid = 1'b0; cpu_addr = '0;
    mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    set_ways('0, '0, '0, '0, 4'b0000, '0, '0, '0, '0);
    cycle();
    cycle();
    checks++; if (cpu_req_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready got=%b exp=1", cpu_req_ready); end
    checks++; if (cpu_rvalid !== 1'b0) begin fails++; $display("[TB] FAIL reset_rvalid got=%b exp=0", cpu_rvalid); end
    checks++; if (cpu_rdata !== 32'h0) begin fails++; $display("[TB] FAIL reset_rdata got=%h exp=0", cpu_rdata); end
    checks++; if ({arr_rd_en, arr_wr_en, mem_req_valid} !== 3'b000) begin fails++; $display("[TB] FAIL reset_enables got=%b exp=000", {arr_rd_en, arr_wr_en, mem_req_valid}); end
    checks++; if (mem_addr !== 32'h0) begin fails++; $display("[TB] FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_miss_basic();
    set_ways('0, '0, '0, '0, 4'b0000, '0, '0, '0, '0);
    cpu_req_valid = 1'b1; cpu_addr = 32'h0000_0404;
    checks++; if (cpu_req_ready !== 1'b1) begin fails++; $display("[TB] FAIL miss_accept_ready got=%b exp=1", cpu_req_ready); end
    cycle();
    cpu_req_valid = 1'b0;
    checks++; if (arr_rd_en !== 1'b1 || arr_index !== 8'h01) begin fails++; $display("[TB] FAIL miss_read got=%b/%h exp=1/01", arr_rd_en, arr_index); end
    cycle();
    checks++; if (arr_rd_en !== 1'b0 || mem_req_valid !== 1'b0) begin fails++; $display("[TB] FAIL miss_lookup got rd=%b mreq=%b exp=0/0", arr_rd_en, mem_req_valid); end
    cycle();
    checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h0000_0404) begin fails++; $display("[TB] FAIL miss_req got=%b/%h exp=1/00000404", mem_req_valid, mem_addr); end
    mem_req_ready = 1'b1;
    cycle();
    mem_req_ready = 1'b0;
    checks++; if (mem_req_valid !== 1'b0) begin fails++; $display("[TB] FAIL miss_wait_mreq got=%b exp=0", mem_req_valid); end
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    cycle();
    mem_rvalid = 1'b0;
    checks++; if (arr_wr_en !== 1'b1 || arr_rd_en !== 1'b0) begin fails++; $display("[TB] FAIL miss_fill_en got wr=%b rd=%b exp=1/0", arr_wr_en, arr_rd_en); end
    checks++; if (arr_wr_way !== 2'd0 || arr_wr_tag !== 22'd1 || arr_wr_data !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL miss_fill got way=%0d tag=%h data=%h exp=0/1/deadbeef", arr_wr_way, arr_wr_tag, arr_wr_data); end
    cycle();
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL miss_resp got=%b/%h exp=1/deadbeef", cpu_rvalid, cpu_rdata); end
    cycle();
    checks++; if (cpu_rvalid !== 1'b0 || cpu_req_ready !== 1'b1 || arr_wr_en !== 1'b0) begin fails++; $display("[TB] FAIL miss_done got rv=%b rdy=%b wr=%b exp=0/1/0", cpu_rvalid, cpu_req_ready, arr_wr_en); end
  endtask

  task automatic test_hit();
    // Way1 matches the tag but is invalid; way3 also hits, so way2 must win as the lowest hit.
    set_ways(22'h3, 22'h15, 22'h15, 22'h15, 4'b1101, 32'h0BAD_0000, 32'h0BAD_0001, 32'h1234_5678, 32'hAAAA_5555);
    cpu_req_valid = 1'b1; cpu_addr = 32'h0000_5408;
    cycle();
    cpu_req_valid = 1'b0;
    checks++; if (arr_rd_en !== 1'b1 || arr_index !== 8'h02 || cpu_rvalid !== 1'b0) begin fails++; $display("[TB] FAIL hit_read got=%b/%h rv=%b exp=1/02/0", arr_rd_en, arr_index, cpu_rvalid); end
    cycle();
    checks++; if (cpu_rvalid !== 1'b0 || mem_req_valid !== 1'b0) begin fails++; $display("[TB] FAIL hit_lookup got rv=%b mreq=%b exp=0/0", cpu_rvalid, mem_req_valid); end
    cycle();
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h1234_5678 || mem_req_valid !== 1'b0) begin fails++; $display("[TB] FAIL hit_resp got=%b/%h mreq=%b exp=1/12345678/0", cpu_rvalid, cpu_rdata, mem_req_valid); end
    cycle();
    checks++; if (cpu_rvalid !== 1'b0 || cpu_req_ready !== 1'b1 || cpu_rdata !== 32'h1234_5678) begin fails++; $display("[TB] FAIL hit_done got rv=%b rdy=%b data=%h exp=0/1/12345678", cpu_rvalid, cpu_req_ready, cpu_rdata); end
  endtask

  task automatic test_plru();
    logic [31:0] rd;
    logic rv, we;
    logic [1:0] way;
    logic [31:0] hit_addr [4];
    hit_addr[0] = 32'h0000_4014; hit_addr[1] = 32'h0000_4414;
    hit_addr[2] = 32'h0000_4814; hit_addr[3] = 32'h0000_4C14;
    pulse_reset();
    set_ways(22'h10, 22'h11, 22'h12, 22'h13, 4'b1111, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    for (int i = 0; i < 4; i++) begin
      do_hit(hit_addr[i], rd, rv);
      checks++; if (rv !== 1'b1 || rd !== 32'hA0 + 32'(i)) begin fails++; $display("[TB] FAIL plru_hit%0d got=%b/%h exp=1/%h", i, rv, rd, 32'hA0 + 32'(i)); end
    end
    do_miss(32'h0000_8014, 32'h0000_00B0, way, we);
    checks++; if (we !== 1'b1 || way !== 2'd0) begin fails++; $display("[TB] FAIL plru_victim_first got we=%b way=%0d exp=1/0", we, way); end
    way_tag0 = 22'h20; way_data0 = 32'hB0;
    do_hit(32'h0000_8014, rd, rv);
    checks++; if (rv !== 1'b1 || rd !== 32'hB0) begin fails++; $display("[TB] FAIL plru_rehit got=%b/%h exp=1/000000b0", rv, rd); end
    do_miss(32'h0000_8414, 32'h0000_00C0, way, we);
    checks++; if (we !== 1'b1 || way !== 2'd2) begin fails++; $display("[TB] FAIL plru_victim_second got we=%b way=%0d exp=1/2", we, way); end
    way_valid3 = 1'b0;
    do_miss(32'h0000_8814, 32'h0000_00D0, way, we);
    checks++; if (we !== 1'b1 || way !== 2'd3) begin fails++; $display("[TB] FAIL invalid_victim got we=%b way=%0d exp=1/3", we, way); end
  endtask

  task automatic test_stall();
    set_ways('0, '0, '0, '0, 4'b0000, '0, '0, '0, '0);
    cpu_req_valid = 1'b1; cpu_addr = 32'h0000_1237;
    cycle();
    cycle();
    cycle();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (mem_req_valid !== 1'b1 || mem_addr !== 32'h0000_1234 || arr_wr_en !== 1'b0 || cpu_req_ready !== 1'b0) begin
        fails++; $display("[TB] FAIL stall_cycle%0d got v=%b a=%h wr=%b rdy=%b exp=1/00001234/0/0", i, mem_req_valid, mem_addr, arr_wr_en, cpu_req_ready);
      end
      cycle();
    end
    cpu_req_valid = 1'b0; mem_req_ready = 1'b1;
    cycle();
    mem_req_ready = 1'b0;
    cycle();
    checks++; if (mem_req_valid !== 1'b0 || arr_wr_en !== 1'b0) begin fails++; $display("[TB] FAIL stall_wait got mreq=%b wr=%b exp=0/0", mem_req_valid, arr_wr_en); end
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    cycle();
    mem_rvalid = 1'b0;
    checks++; if (arr_wr_en !== 1'b1 || arr_wr_tag !== 22'h4) begin fails++; $display("[TB] FAIL stall_fill got wr=%b tag=%h exp=1/4", arr_wr_en, arr_wr_tag); end
    cycle();
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h5555_AAAA) begin fails++; $display("[TB] FAIL stall_resp got=%b/%h exp=1/5555aaaa", cpu_rvalid, cpu_rdata); end
    cycle();
  endtask

  task automatic test_reset_mid_miss();
    set_ways('0, '0, '0, '0, 4'b0000, '0, '0, '0, '0);
    cpu_req_valid = 1'b1; cpu_addr = 32'h0000_2000;
    cycle();
    cpu_req_valid = 1'b0;
    cycle();
    cycle();
    mem_req_ready = 1'b1;
    cycle();
    mem_req_ready = 1'b0; rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++; if (cpu_req_ready !== 1'b1 || cpu_rdata !== 32'h0) begin fails++; $display("[TB] FAIL midreset_state got rdy=%b data=%h exp=1/0", cpu_req_ready, cpu_rdata); end
    mem_rvalid = 1'b1; mem_rdata = 32'hFEED_F00D;
    cycle();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (arr_wr_en !== 1'b0 || cpu_rvalid !== 1'b0 || cpu_req_ready !== 1'b1) begin
        fails++; $display("[TB] FAIL midreset_idle%0d got wr=%b rv=%b rdy=%b exp=0/0/1", i, arr_wr_en, cpu_rvalid, cpu_req_ready);
      end
      cycle();
    end
  endtask

`ifdef CACHE_MISS_CTRL_STATS_EN
  task automatic test_stats();
    logic [31:0] rd;
    logic rv, we;
    logic [1:0] way;
    pulse_reset();
    checks++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin fails++; $display("[TB] FAIL stats_reset got=%h/%h exp=0/0", hit_count, miss_count); end
    set_ways(22'h10, 22'h11, 22'h12, 22'h13, 4'b1111, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    do_hit(32'h0000_4014, rd, rv);
    do_hit(32'h0000_4414, rd, rv);
    do_miss(32'h0000_9014, 32'h0000_00E0, way, we);
    checks++; if (hit_count !== 16'd2 || miss_count !== 16'd1) begin fails++; $display("[TB] FAIL stats_counts got=%0d/%0d exp=2/1", hit_count, miss_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_miss_basic();
    test_hit();
    test_plru();
    test_stall();
    test_reset_mid_miss();
`ifdef CACHE_MISS_CTRL_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
